// File: rtl/mux2_1_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module      : mux2_1_rr_arbiter
// Description : Round-robin arbiter sharing one 2:1 mux datapath between two
//               requesters, with registered grant/selector and a valid/ready
//               output. Optional hold-limit preemption is enabled by defining
//               the macro MUX2_1_ARB_HOLD_LIMIT_EN.
// Revision    : 1.0 - initial release
//============================================================================
module mux2_1_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             out_ready,
    output logic             gnt0,
    output logic             gnt1,
    output logic             selector,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_selector;
    logic   w_next_selector;
    logic   r_last_served;
    logic   w_next_last_served;
    logic   w_hold_limit0;
    logic   w_hold_limit1;

`ifdef MUX2_1_ARB_HOLD_LIMIT_EN
    logic [7:0] r_hold_cnt;
    logic       w_xfer;
    logic       w_hold_last;

    assign w_xfer      = out_valid & out_ready;
    // Transfer happening now would be the holder's last allowed one.
    assign w_hold_last = w_xfer && (({1'b0, r_hold_cnt} + 9'd1) == MAX_HOLD[8:0]);
    assign w_hold_limit0 = w_hold_last & req1;
    assign w_hold_limit1 = w_hold_last & req0;
`else
    // Without hold limiting, the ready input and MAX_HOLD have no effect.
    logic w_unused_ready;
    localparam int c_unused_max_hold = MAX_HOLD;
    assign w_unused_ready = out_ready;
    assign w_hold_limit0  = 1'b0;
    assign w_hold_limit1  = 1'b0;
`endif

    assign gnt0      = (r_state == GRANT0);
    assign gnt1      = (r_state == GRANT1);
    assign selector  = r_selector;
    assign out_valid = (gnt0 & req0) | (gnt1 & req1);
    assign out_data  = r_selector ? data1 : data0;

    // Next-state decision: IDLE round-robin, holder drop handoff, hold-limit preemption.
    always_comb begin
        w_next_state       = r_state;
        w_next_last_served = r_last_served;
        unique case (r_state)
            IDLE: begin
                if (req0 && req1) begin
                    w_next_state = r_last_served ? GRANT0 : GRANT1;
                end else if (req0) begin
                    w_next_state = GRANT0;
                end else if (req1) begin
                    w_next_state = GRANT1;
                end
            end
            GRANT0: begin
                // Drop takes precedence over the hold limit.
                if (!req0) begin
                    w_next_state       = req1 ? GRANT1 : IDLE;
                    w_next_last_served = 1'b0;
                end else if (w_hold_limit0) begin
                    w_next_state       = GRANT1;
                    w_next_last_served = 1'b0;
                end
            end
            GRANT1: begin
                if (!req1) begin
                    w_next_state       = req0 ? GRANT0 : IDLE;
                    w_next_last_served = 1'b1;
                end else if (w_hold_limit1) begin
                    w_next_state       = GRANT0;
                    w_next_last_served = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Selector follows the grant on the same edge; it keeps its value through IDLE.
    always_comb begin
        w_next_selector = r_selector;
        if (w_next_state == GRANT0) begin
            w_next_selector = 1'b0;
        end else if (w_next_state == GRANT1) begin
            w_next_selector = 1'b1;
        end
    end

    // State, selector and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_selector    <= 1'b0;
            r_last_served <= 1'b1;
        end else begin
            r_state       <= w_next_state;
            r_selector    <= w_next_selector;
            r_last_served <= w_next_last_served;
        end
    end

`ifdef MUX2_1_ARB_HOLD_LIMIT_EN
    // Consecutive-transfer counter: cleared on any grant change, saturates at MAX_HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= 8'd0;
        end else if (w_next_state != r_state) begin
            r_hold_cnt <= 8'd0;
        end else if (w_xfer && (r_hold_cnt != MAX_HOLD[7:0])) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux2_1_rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module      : tb_mux2_1_rr_arbiter
// Description : Directed self-checking bench for mux2_1_rr_arbiter.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mux2_1_rr_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;
`ifdef MUX2_1_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             out_ready;
    logic             gnt0;
    logic             gnt1;
    logic             selector;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;

    int n_checks;
    int n_fail;

    mux2_1_rr_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .out_ready (out_ready),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .selector  (selector),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    // 10 ns clock, rising edge active.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One active edge, then settle at the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Check grant/selector/valid/data against the expected holder (0 or 1).
    task automatic check_holder(input string tag, input bit holder);
        check({tag, ".gnt0"}, {31'd0, gnt0}, {31'd0, !holder});
        check({tag, ".gnt1"}, {31'd0, gnt1}, {31'd0, holder});
        check({tag, ".sel"}, {31'd0, selector}, {31'd0, holder});
        check({tag, ".data"}, {24'd0, out_data}, holder ? 32'h5A : 32'hA5);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req0      = 1'b0;
        req1      = 1'b0;
        data0     = 8'h11;
        data1     = 8'h22;
        out_ready = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst.gnt0", {31'd0, gnt0}, 32'd0);
        check("rst.gnt1", {31'd0, gnt1}, 32'd0);
        check("rst.sel", {31'd0, selector}, 32'd0);
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.data", {24'd0, out_data}, 32'h11);

        // Single requester: no switch regardless of the hold limit.
        rst_n     = 1'b1;
        data0     = 8'hA5;
        data1     = 8'h5A;
        req0      = 1'b1;
        out_ready = 1'b1;
        #1;
        check("single.pre_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_holder("single", 1'b0);
            check("single.valid", {31'd0, out_valid}, 32'd1);
        end
        req0 = 1'b0;
        #1;
        check("single.drop_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("single.idle_gnt0", {31'd0, gnt0}, 32'd0);

        // Tie right after reset: requester 0 wins first.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_holder("tie", HOLD_EN && ((i % 8) >= 4));
            check("tie.valid", {31'd0, out_valid}, 32'd1);
        end

        // Holder 0 drops with 1 waiting: handoff on the next edge in both builds.
        req0 = 1'b0;
        #1;
        check("drop0.valid", {31'd0, out_valid}, 32'd0);
        tick();
        check_holder("drop0", 1'b1);

        // Return to GRANT0 via a drop of requester 1, then stall with 1 waiting.
        req0 = 1'b1;
        req1 = 1'b0;
        tick();
        check_holder("bp.enter", 1'b0);
        req1      = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_holder("bp.stall", 1'b0);
            check("bp.valid", {31'd0, out_valid}, 32'd1);
        end
        // Count resumes from zero: switch after the fourth accepted transfer.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_holder("bp.resume", HOLD_EN && (i == 3));
        end

        // Put requester 1 on the grant in either build.
        req0 = 1'b0;
        tick();
        check_holder("h1.enter", 1'b1);
        req0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_holder("h1.xfer", 1'b1);
        end
        // Holder 1 drops: valid falls at once, grant moves next edge with a fresh count.
        req1 = 1'b0;
        #1;
        check("drop1.valid", {31'd0, out_valid}, 32'd0);
        tick();
        check_holder("drop1", 1'b0);
        req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_holder("drop1.count", HOLD_EN && (i == 3));
        end

        // Reset mid-burst while requester 1 holds the grant.
        req0 = 1'b0;
        tick();
        req0 = 1'b1;
        tick();
        check_holder("midrst.pre", 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.gnt0", {31'd0, gnt0}, 32'd0);
        check("midrst.gnt1", {31'd0, gnt1}, 32'd0);
        check("midrst.sel", {31'd0, selector}, 32'd0);
        check("midrst.valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req0  = 1'b0;
        req1  = 1'b1;
        tick();
        check_holder("midrst.post", 1'b1);
        check("midrst.post_valid", {31'd0, out_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux2_1_rr_arbiter.md
Name: mux2_1_rr_arbiter

Overview:
- Round-robin arbiter that shares one 2:1 mux datapath between two requesters.
- Grants one requester at a time and drives the mux `selector` from a registered grant.
- Presents the selected requester's data to a single downstream consumer through a valid/ready handshake.
- Sits directly in front of the mux2_1 datapath and replaces free-running selector toggling with demand-driven sequencing.

Parameters:
- WIDTH, 8, data width of each requester input and of `out_data`.
- MAX_HOLD, 4, maximum consecutive accepted transfers for one grant holder before it must yield to a waiting requester (range 1..255).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 (mux input1) wants the datapath.
- req1  input  1  requester 1 (mux input2) wants the datapath.
- data0  input  WIDTH  requester 0 data.
- data1  input  WIDTH  requester 1 data.
- out_ready  input  1  downstream accepts `out_data` this cycle.
- gnt0  output  1  requester 0 holds the datapath (registered).
- gnt1  output  1  requester 1 holds the datapath (registered).
- selector  output  1  mux select; 0 selects input1/data0, 1 selects input2/data1 (registered).
- out_valid  output  1  `out_data` is valid.
- out_data  output  WIDTH  muxed data.

Behaviour:
- Reset:
  - Asynchronous on rst_n low, takes effect immediately, including mid-transfer.
  - State = IDLE; gnt0 = gnt1 = 0; selector = 0; hold_cnt = 0; last_served = 1, so requester 0 wins the first tie.
  - out_valid = 0; out_data = data0, following selector = 0.
- FSM states: IDLE, GRANT0, GRANT1. gnt0 = (state == GRANT0); gnt1 = (state == GRANT1). Never both high.
- Combinational outputs from registered state:
  - out_valid = (gnt0 & req0) | (gnt1 & req1).
  - out_data = selector ? data1 : data0.
- Transfer: a transfer occurs on a cycle with out_valid & out_ready. hold_cnt increments on each transfer, saturating at MAX_HOLD.
- IDLE transitions:
  - Only req0 high: go to GRANT0.
  - Only req1 high: go to GRANT1.
  - Both high: grant the requester that is not last_served.
  - Neither high: stay in IDLE.
  - On entering any grant state: hold_cnt = 0; selector is updated in the same edge.
- GRANTx transitions, in priority order:
  1. Holder deasserts req: leave. Go to the other GRANT if the other requester is requesting, else IDLE. last_served = x.
  2. Hold limit: a transfer occurs this cycle, hold_cnt + 1 == MAX_HOLD, and the other requester is requesting. Switch to the other GRANT; last_served = x.
  3. Otherwise stay.
- Latency: a request arriving in IDLE is granted on the next edge; first valid data appears one cycle after the request.
- Stalls: with out_ready low, the grant is held indefinitely; hold_cnt does not advance and there is no preemption.
- Switch timing: the switch edge updates selector and gnt together. out_data never shows the new requester's data while the old grant is still asserted.
- Simultaneous events:
  - Holder drop and hold-limit in the same cycle: the drop rule (rule 1) applies.
  - Both requests rising together in IDLE: round-robin via last_served.
- Registered grant means a requester dropping req sees out_valid fall immediately, since out_valid is gated by req, while gnt falls on the next edge.

Optional Feature:
- Macro: MUX2_1_ARB_HOLD_LIMIT_EN.
- Defined: hold-limit preemption (rule 2) is active as described above.
- Undefined:
  - Rule 2 is removed and hold_cnt is not implemented.
  - A holder keeps the grant until it deasserts req.
  - Round-robin applies only at IDLE decisions and on drop handoffs.
  - MAX_HOLD is ignored.

Test Plan:
- Reset mid-burst: GRANT1 active with transfers in flight, drive rst_n = 0 asynchronously between edges -> gnt0 = gnt1 = 0, selector = 0, out_valid = 0 before the next edge. After release, req1 alone -> gnt1 one edge later.
- Single requester: req0 = 1, data0 = 8'hA5, out_ready = 1 for 10 cycles, req1 = 0 -> gnt0 = 1 and selector = 0 from cycle 1, out_valid = 1, out_data = A5. No switch despite MAX_HOLD = 4.
- Tie from reset: req0 = req1 = 1 in the same cycle after reset -> GRANT0 first. With out_ready = 1 and the macro defined: 4 transfers of data0, then selector = 1 and gnt1 = 1; 4 transfers of data1, then back to GRANT0.
- Backpressure: GRANT0 with req1 waiting, out_ready = 0 for 20 cycles -> gnt0 held, out_valid = 1 and out_data stable, no preemption. Releasing out_ready resumes the hold count from 0.
- Holder drop handoff: GRANT1 after 2 transfers, req1 falls while req0 = 1 -> out_valid = 0 that cycle; next edge gnt0 = 1, selector = 0, hold_cnt = 0.
- Macro undefined: req0 = req1 = 1 with out_ready = 1 for 12 cycles -> gnt0 held for all 12 cycles. Dropping req0 -> GRANT1 on the next edge.
